// File: rtl/sopc4_in_c0.sv
// Parallel input port with Avalon-MM slave access: synchronised data readback,
// per-bit edge capture with write-1-to-clear, and a maskable interrupt.
module sopc4_in_c0 #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EDGE_TYPE = 0,  // 0 rising, 1 falling, 2 any
    parameter int unsigned IRQ_TYPE  = 0   // 0 edge-driven, 1 level-driven
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] wdata_w;
    logic [31:0]      rd_mux;
    logic             wr_en, rd_en;

    // Bits of writedata above WIDTH are deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Per-bit edge detect between the synchronised sample and its history.
    always_comb begin
        edge_w = '0;
        if (EDGE_TYPE == 0) begin
            edge_w = s2_q & ~s3_q;
        end else if (EDGE_TYPE == 1) begin
            edge_w = ~s2_q & s3_q;
        end else begin
            edge_w = s2_q ^ s3_q;
        end
    end

    // Register decode, read mux and next-state for mask, capture and readdata.
    always_comb begin
        wr_en      = chipselect && !write_n;
        rd_en      = chipselect && !read_n;
        wdata_w    = writedata[WIDTH-1:0];
        rd_mux     = '0;
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q;
        readdata_d = readdata_q;

        unique case (address)
            2'd0:    rd_mux[WIDTH-1:0] = s2_q;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask_q;
            2'd3:    rd_mux[WIDTH-1:0] = edgecap_q;
            default: rd_mux = '0;
        endcase

        if (rd_en) begin
            readdata_d = rd_mux;
        end
        if (wr_en && address == 2'd2) begin
            irqmask_d = wdata_w;
        end
        if (wr_en && address == 2'd3) begin
            edgecap_d = edgecap_q & ~wdata_w;
        end
        // A new edge wins over a simultaneous clear of the same bit.
        edgecap_d = edgecap_d | edge_w;
    end

    // State update; synchronous reset overrides any access or edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    // Interrupt is a pure function of registered state.
    always_comb begin
        if (IRQ_TYPE == 0) begin
            irq = |(edgecap_q & irqmask_q);
        end else begin
            irq = |(s2_q & irqmask_q);
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_sopc4_in_c0.sv
// Bench for sopc4_in_c0: three parameterisations share one bus and input,
// checked by a scoreboard fed from a sample-history reference model.
module tb_sopc4_in_c0;

    localparam int N = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      = 1'b1;
    logic        chipselect = 1'b0;
    logic        read_n     = 1'b1;
    logic        write_n    = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic [31:0] writedata  = '0;
    logic [31:0] in_port    = '0;

    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    sopc4_in_c0 #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd0), .irq(irq0)
    );
    sopc4_in_c0 #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(0)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port[7:0]), .readdata(rd1), .irq(irq1)
    );
    sopc4_in_c0 #(.WIDTH(12), .EDGE_TYPE(1), .IRQ_TYPE(1)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port[11:0]), .readdata(rd2), .irq(irq2)
    );

    logic [31:0] dut_rd[N];
    logic [N-1:0] dut_irq;
    assign dut_rd[0] = rd0;
    assign dut_rd[1] = rd1;
    assign dut_rd[2] = rd2;
    assign dut_irq   = {irq2, irq1, irq0};

    int unsigned p_w[N] = '{32, 8, 12};
    int unsigned p_e[N] = '{0, 2, 1};
    int unsigned p_i[N] = '{0, 0, 1};

    // Model: input samples taken 1, 2 and 3 edges ago plus register contents.
    logic [31:0] h1[N], h2[N], h3[N];
    logic [31:0] m_mask[N], m_ec[N], m_rd[N];

    typedef struct packed {
        logic [N-1:0]       irq;
        logic [N-1:0][31:0] rd;
    } exp_t;
    typedef logic [N-1:0][31:0] rsp_t;

    exp_t cyc_q[$];
    rsp_t rsp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int i);
        if (p_w[i] >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << p_w[i]) - 32'h1;
    endfunction

    // Advance the model over the coming edge, then hand expectations to the monitor.
    task automatic step();
        exp_t        e;
        rsp_t        r;
        logic        rd_en, wr_en;
        logic [31:0] m, s2, s3, ev, view;
        rd_en = chipselect && !read_n;
        wr_en = chipselect && !write_n;
        e = '0;
        r = '0;
        for (int i = 0; i < N; i++) begin
            m  = wmask(i);
            s2 = h2[i];
            s3 = h3[i];
            if (reset) begin
                h1[i] = '0; h2[i] = '0; h3[i] = '0;
                m_mask[i] = '0; m_ec[i] = '0; m_rd[i] = '0;
            end else begin
                case (p_e[i])
                    0:       ev = s2 & ~s3;
                    1:       ev = ~s2 & s3;
                    default: ev = s2 ^ s3;
                endcase
                ev = ev & m;
                case (address)
                    2'd0:    view = s2;
                    2'd2:    view = m_mask[i];
                    2'd3:    view = m_ec[i];
                    default: view = '0;
                endcase
                r[i] = view;
                if (rd_en) m_rd[i] = view;
                if (wr_en && address == 2'd3) m_ec[i] = m_ec[i] & ~(writedata & m);
                m_ec[i] = m_ec[i] | ev;
                if (wr_en && address == 2'd2) m_mask[i] = writedata & m;
                h3[i] = h2[i];
                h2[i] = h1[i];
                h1[i] = in_port & m;
            end
            e.rd[i]  = m_rd[i];
            e.irq[i] = (p_i[i] == 0) ? |(m_ec[i] & m_mask[i]) : |(h2[i] & m_mask[i]);
        end
        @(posedge clk);
        cyc_q.push_back(e);
        if (rd_en && !reset) rsp_q.push_back(r);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic bus(input logic rn, input logic wn, input logic [1:0] a,
                       input logic [31:0] d);
        chipselect = 1'b1; read_n = rn; write_n = wn; address = a; writedata = d;
        step();
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b0, 1'b1, a, 32'h0);
    endtask

    // Monitor: every cycle compare held readdata and irq; on a read, compare the response.
    initial begin
        exp_t e;
        rsp_t r;
        logic saw;
        forever begin
            @(posedge clk);
            saw = chipselect && !read_n && !reset;
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("readdata_dut%0d", i), dut_rd[i], e.rd[i]);
                    check($sformatf("irq_dut%0d", i), {31'b0, dut_irq[i]}, {31'b0, e.irq[i]});
                end
            end
            if (saw) begin
                if (rsp_q.size() == 0) begin
                    check("read_response_queued", 32'd0, 32'd1);
                end else begin
                    r = rsp_q.pop_front();
                    for (int i = 0; i < N; i++)
                        check($sformatf("read_rsp_dut%0d", i), dut_rd[i], r[i]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            h1[i] = '0; h2[i] = '0; h3[i] = '0;
            m_mask[i] = '0; m_ec[i] = '0; m_rd[i] = '0;
        end
        idle(2);
        reset = 1'b0;
        idle(3);

        // Rising edge capture and data readback.
        in_port = 32'h5;
        idle(3);
        rd(2'd3);
        check("ec_after_rise", rd0, 32'h5);
        rd(2'd0);
        check("data_read", rd0, 32'h5);
        rd(2'd1);
        check("reserved_read", rd0, 32'h0);

        // Mask, interrupt, partial clear.
        wr(2'd2, 32'h4);
        check("irq_masked_edge", {31'b0, irq0}, 32'h1);
        wr(2'd3, 32'h4);
        check("irq_after_clear", {31'b0, irq0}, 32'h0);
        rd(2'd3);
        check("ec_partial_clear", rd0, 32'h1);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0);
        check("data_write_ignored", rd0, 32'h5);

        // Set wins over a simultaneous clear.
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h0;
        idle(3);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h1;
        idle(2);
        wr(2'd3, 32'h1);
        rd(2'd3);
        check("set_beats_clear", rd0 & 32'h1, 32'h1);

        // Any-edge instance: pulse bit 3 for four cycles.
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h8;
        idle(4);
        in_port = 32'h0;
        wr(2'd3, 32'h8);
        rd(2'd3);
        check("any_edge_cleared", rd1 & 32'h8, 32'h0);
        step();
        rd(2'd3);
        check("any_edge_fall", rd1 & 32'h8, 32'h8);

        // Level interrupt instance.
        wr(2'd2, 32'h1);
        in_port = 32'h1;
        step();
        check("level_irq_one_edge", {31'b0, irq2}, 32'h0);
        step();
        check("level_irq_set", {31'b0, irq2}, 32'h1);
        in_port = 32'h0;
        idle(2);
        check("level_irq_clear", {31'b0, irq2}, 32'h0);

        // Reset with edges pending and a concurrent access.
        wr(2'd2, 32'hFF);
        in_port = 32'hFF;
        idle(3);
        rd(2'd2);
        reset = 1'b1;
        wr(2'd2, 32'h3);
        check("reset_readdata", rd0, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);
        reset = 1'b0;
        idle(3);
        rd(2'd3);
        check("held_high_across_reset", rd0, 32'hFF);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 63) == 0);
            chipselect = $urandom_range(0, 1);
            read_n     = $urandom_range(0, 1);
            write_n    = ($urandom_range(0, 2) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = $urandom;
            step();
        end
        reset = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        idle(2);
        @(negedge clk);
        @(negedge clk);
        check("cyc_queue_drained", cyc_q.size(), 32'd0);
        check("rsp_queue_drained", rsp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sopc4_in_c0.md
SOPC4_IN_C0 -- requirements
Module: sopc4_in_c0

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of in_port and of every register (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 0: capture edge, 0=rising, 1=falling, 2=any.
REQ-003 SHALL have parameter IRQ_TYPE, default 0: 0=edge (irq from edgecapture), 1=level (irq from synchronized input).
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port address, input, 2: Avalon-MM slave register select.
REQ-007 SHALL have port chipselect, input, 1: slave selected.
REQ-008 SHALL have port read_n, input, 1: active-low read strobe.
REQ-009 SHALL have port write_n, input, 1: active-low write strobe.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port in_port, input, WIDTH: asynchronous external inputs.
REQ-012 SHALL have port readdata, output, 32: registered read data, zero-extended above WIDTH.
REQ-013 SHALL have port irq, output, 1: active-high level interrupt request.

Function
REQ-014 SHALL pass in_port through a 2-flop synchronizer (s1, s2) plus a history flop s3 holding the previous s2.
REQ-015 SHALL define the per-bit edge as s2&~s3 (EDGE_TYPE 0), ~s2&s3 (1), s2^s3 (2).
REQ-016 SHALL use this register map: addr 0 data (RO, value s2); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (RW); addr 3 edgecapture (RO, write-1-to-clear).
REQ-017 SHALL treat a write as chipselect=1 and write_n=0 in a cycle; it takes effect at that clock edge, using writedata[WIDTH-1:0].
REQ-018 SHALL treat a read as chipselect=1 and read_n=0; readdata SHALL be loaded at that edge (read latency 1) and SHALL hold its value until the next read.
REQ-019 SHALL set each edgecapture bit when its edge term is 1 and keep it set until cleared by a write of 1 to that bit at addr 3.
REQ-020 SHALL give set priority over clear when an edge and a clearing write hit the same bit in the same cycle (bit stays 1).
REQ-021 SHALL drive irq = |(edgecapture & irqmask) when IRQ_TYPE=0, and |(s2 & irqmask) when IRQ_TYPE=1; it is combinational from registers only.
REQ-022 SHALL set the in_port to edgecapture latency at exactly 3 clk edges: s1 at edge k, s2 at k+1, edgecapture and irq at k+2.
REQ-023 SHALL return data that reflects in_port 2 edges after sampling, so a read issued at edge k+2 or later returns the new value.
REQ-024 SHALL give writes to addr 0 no effect, and a read with write strobe also active SHALL perform both actions.
REQ-025 SHALL make an edgecapture read in the same cycle as a new edge return the pre-update value; the new bit is visible on the next read.
REQ-026 SHALL ignore bits of writedata above WIDTH and drive readdata bits above WIDTH to 0.

Reset
REQ-027 SHALL clear s1, s2, s3, irqmask, edgecapture and readdata to 0 on reset=1 at a clk edge; irq SHALL then be 0.
REQ-028 SHALL give reset priority over any simultaneous access or edge event.
REQ-029 SHALL capture a rising edge from an input held high across reset release when EDGE_TYPE is 0 or 2; this is defined behaviour.

Verification
REQ-030 SHALL cover this scenario: WIDTH=32, EDGE_TYPE=0, in_port 0->0x00000005 at edge k -> edgecapture=0x5 at k+2; read addr 0 -> readdata 0x5 one cycle after the strobe.
REQ-031 SHALL cover this scenario: irqmask=0x4, capture 0x5 -> irq=1; write 0x4 to addr 3 -> irq=0 next cycle, edgecapture reads 0x1.
REQ-032 SHALL cover this scenario: rising edge on bit 0 in the same cycle as a write of 0x1 to addr 3 -> edgecapture bit 0 remains 1.
REQ-033 SHALL cover this scenario: EDGE_TYPE=2, pulse bit 3 high for 4 cycles -> bit 3 set after rise; clear it; bit 3 set again after fall.
REQ-034 SHALL cover this scenario: IRQ_TYPE=1, irqmask=0x1, in_port=0x1 -> irq=1 after 2 edges, in_port=0 -> irq=0 after 2 edges, edgecapture irrelevant.
REQ-035 SHALL cover this scenario: irqmask=0xFF with edges pending, assert reset one cycle -> readdata=0, irqmask=0, edgecapture=0, irq=0 at next edge.
